// File: rtl/spiadc_pkg.sv
// spiadc_pkg: shared definitions for the SPI ADC acquisition path.
//   - seq_state_t : acquisition sequencer states
//   - NUM_IN_DEF / DATA_SIZE_DEF : default frame length and sample width
//   - state_is_busy() : busy decode shared by RTL and bench
package spiadc_pkg;

    localparam int unsigned NUM_IN_DEF    = 16;
    localparam int unsigned DATA_SIZE_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_TICK   = 3'd1,
        ST_CONV        = 3'd2,
        ST_WAIT_STEP   = 3'd3,
        ST_WAIT_RESULT = 3'd4,
        ST_ERR         = 3'd5
    } seq_state_t;

    // Busy means a sample or decision is in flight (or the sequencer is parked in ERR).
    function automatic logic state_is_busy(input seq_state_t s);
        return !((s == ST_IDLE) || (s == ST_WAIT_TICK));
    endfunction

endpackage

// File: rtl/period_timer.sv
// period_timer: free-running sample-period counter.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_run        : count while high, hold otherwise
//   i_reload     : force the count back to zero (wins over i_run)
//   i_period     : clocks between ticks; 0 behaves as 1
//   o_tick_c     : combinational tick, high on the last count of each period
module period_timer #(
    parameter int unsigned PERIOD_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_run,
    input  logic                i_reload,
    input  logic [PERIOD_W-1:0] i_period,
    output logic                o_tick_c
);

    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] w_last;

    // Terminal count is max(period,1)-1; >= keeps a shrinking period from running away.
    assign w_last   = (i_period == '0) ? '0 : (i_period - PERIOD_W'(1));
    assign o_tick_c = i_run && !i_reload && (r_count >= w_last);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_reload) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= o_tick_c ? '0 : (r_count + PERIOD_W'(1));
        end
    end

endmodule

// File: rtl/adc_frame_seq.sv
// adc_frame_seq: paces ADC conversions and feeds a frame of samples to the
// Manhattan-distance classifier, then collects its two-class decision.
//   clk, reset             : clock, asynchronous active-low reset
//   enable                 : run acquisition; low parks in IDLE and clears sticky flags
//   period                 : clocks between conversion starts (0 acts as 1)
//   adc_start/adc_done/adc_data : ADC conversion handshake
//   net_int/net_data       : sample strobe and data to classifier
//   net_step/net_ready/net_out  : classifier step ack, result ready, decision bit
//   class_valid/class_out  : decision pulse and last decision
//   frame_cnt, sample_idx  : completed frames, current sample index
//   busy, timeout_err, overrun : status (timeout_err/overrun sticky)
module adc_frame_seq
    import spiadc_pkg::*;
#(
    parameter int unsigned NUM_IN    = NUM_IN_DEF,
    parameter int unsigned ADDR_SIZE = 4,
    parameter int unsigned DATA_SIZE = DATA_SIZE_DEF,
    parameter int unsigned PERIOD_W  = 16,
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned FRAME_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [PERIOD_W-1:0]  period,
    output logic                 adc_start,
    input  logic                 adc_done,
    input  logic [DATA_SIZE-1:0] adc_data,
    output logic                 net_int,
    output logic [DATA_SIZE-1:0] net_data,
    input  logic                 net_step,
    input  logic                 net_ready,
    input  logic                 net_out,
    output logic                 class_valid,
    output logic                 class_out,
    output logic [FRAME_W-1:0]   frame_cnt,
    output logic [ADDR_SIZE-1:0] sample_idx,
    output logic                 busy,
    output logic                 timeout_err,
    output logic                 overrun
);

    localparam int unsigned          TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]      TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [ADDR_SIZE-1:0] IDX_LAST = ADDR_SIZE'(NUM_IN - 1);

    seq_state_t r_state, w_next_state;

    logic [TO_W-1:0]      r_to_cnt, w_to_cnt;
    logic                 r_step_q, r_ready_q;
    logic                 w_step_rise, w_ready_rise;
    logic                 w_tick, w_timer_run, w_timer_reload;
    logic                 w_event;

    logic                 r_adc_start, w_adc_start;
    logic                 r_net_int, w_net_int;
    logic [DATA_SIZE-1:0] r_net_data, w_net_data;
    logic                 r_class_valid, w_class_valid;
    logic                 r_class_out, w_class_out;
    logic [FRAME_W-1:0]   r_frame_cnt, w_frame_cnt;
    logic [ADDR_SIZE-1:0] r_sample_idx, w_sample_idx;
    logic                 r_busy;
    logic                 r_timeout_err, w_timeout_err;
    logic                 r_overrun, w_overrun;

    // Sample timer runs whenever acquisition is active; held at zero in IDLE.
    assign w_timer_run    = enable && (r_state != ST_IDLE);
    assign w_timer_reload = (r_state == ST_IDLE);

    period_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (reset),
        .i_run    (w_timer_run),
        .i_reload (w_timer_reload),
        .i_period (period),
        .o_tick_c (w_tick)
    );

    // Classifier handshakes are levels; only their rising edges count.
    assign w_step_rise  = net_step  && !r_step_q;
    assign w_ready_rise = net_ready && !r_ready_q;

    // The event each waiting state is watching for.
    always_comb begin
        w_event = 1'b0;
        unique case (r_state)
            ST_CONV:        w_event = adc_done;
            ST_WAIT_STEP:   w_event = w_step_rise;
            ST_WAIT_RESULT: w_event = w_ready_rise;
            default:        w_event = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        w_next_state  = r_state;
        w_to_cnt      = r_to_cnt;
        w_adc_start   = 1'b0;
        w_net_int     = 1'b0;
        w_class_valid = 1'b0;
        w_net_data    = r_net_data;
        w_class_out   = r_class_out;
        w_frame_cnt   = r_frame_cnt;
        w_sample_idx  = r_sample_idx;
        w_timeout_err = r_timeout_err;
        // A tick that cannot start a conversion is dropped and remembered.
        w_overrun     = r_overrun || (w_tick && (r_state != ST_WAIT_TICK));

        if (!enable) begin
            w_next_state  = ST_IDLE;
            w_to_cnt      = '0;
            w_sample_idx  = '0;
            w_timeout_err = 1'b0;
            w_overrun     = 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_WAIT_TICK;
                end
                ST_WAIT_TICK: begin
                    if (w_tick) begin
                        w_next_state = ST_CONV;
                        w_adc_start  = 1'b1;
                        w_to_cnt     = '0;
                    end
                end
                ST_CONV, ST_WAIT_STEP, ST_WAIT_RESULT: begin
                    if (!w_event) begin
                        // The event wins over a timeout landing on the same cycle.
                        if (r_to_cnt == TO_LAST) begin
                            w_next_state  = ST_ERR;
                            w_timeout_err = 1'b1;
                            w_sample_idx  = '0;
                        end else begin
                            w_to_cnt = r_to_cnt + TO_W'(1);
                        end
                    end else if (r_state == ST_CONV) begin
                        w_net_data   = adc_data;
                        w_net_int    = 1'b1;
                        w_to_cnt     = '0;
                        w_next_state = ST_WAIT_STEP;
                    end else if (r_state == ST_WAIT_STEP) begin
                        if (r_sample_idx == IDX_LAST) begin
                            w_to_cnt     = '0;
                            w_next_state = ST_WAIT_RESULT;
                        end else begin
                            w_sample_idx = r_sample_idx + ADDR_SIZE'(1);
                            w_next_state = ST_WAIT_TICK;
                        end
                    end else begin
                        w_class_out   = net_out;
                        w_class_valid = 1'b1;
                        w_frame_cnt   = r_frame_cnt + FRAME_W'(1);
                        w_sample_idx  = '0;
                        w_next_state  = ST_WAIT_TICK;
                    end
                end
                ST_ERR: begin
                    w_next_state = ST_ERR;
                end
                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Registered outputs, timeout counter and edge-detect history.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_to_cnt      <= '0;
            r_step_q      <= 1'b0;
            r_ready_q     <= 1'b0;
            r_adc_start   <= 1'b0;
            r_net_int     <= 1'b0;
            r_net_data    <= '0;
            r_class_valid <= 1'b0;
            r_class_out   <= 1'b0;
            r_frame_cnt   <= '0;
            r_sample_idx  <= '0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_to_cnt      <= w_to_cnt;
            r_step_q      <= net_step;
            r_ready_q     <= net_ready;
            r_adc_start   <= w_adc_start;
            r_net_int     <= w_net_int;
            r_net_data    <= w_net_data;
            r_class_valid <= w_class_valid;
            r_class_out   <= w_class_out;
            r_frame_cnt   <= w_frame_cnt;
            r_sample_idx  <= w_sample_idx;
            r_busy        <= state_is_busy(w_next_state);
            r_timeout_err <= w_timeout_err;
            r_overrun     <= w_overrun;
        end
    end

    assign adc_start   = r_adc_start;
    assign net_int     = r_net_int;
    assign net_data    = r_net_data;
    assign class_valid = r_class_valid;
    assign class_out   = r_class_out;
    assign frame_cnt   = r_frame_cnt;
    assign sample_idx  = r_sample_idx;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_adc_frame_seq.sv
// tb_adc_frame_seq: directed bench for adc_frame_seq with a latency-programmable
// ADC model and a classifier model (step ack and decision per frame).
module tb_adc_frame_seq;
    import spiadc_pkg::*;

    localparam int unsigned NUM_IN    = 16;
    localparam int unsigned ADDR_SIZE = 4;
    localparam int unsigned DATA_SIZE = 8;
    localparam int unsigned PERIOD_W  = 16;
    localparam int unsigned TIMEOUT   = 255;
    localparam int unsigned FRAME_W   = 8;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [PERIOD_W-1:0]  period;
    logic                 adc_start;
    logic                 adc_done;
    logic [DATA_SIZE-1:0] adc_data;
    logic                 net_int;
    logic [DATA_SIZE-1:0] net_data;
    logic                 net_step;
    logic                 net_ready;
    logic                 net_out;
    logic                 class_valid;
    logic                 class_out;
    logic [FRAME_W-1:0]   frame_cnt;
    logic [ADDR_SIZE-1:0] sample_idx;
    logic                 busy;
    logic                 timeout_err;
    logic                 overrun;

    // Bench controls (written by the stimulus process only)
    logic step_m, man_step;
    int   cls_auto, adc_resp, adc_lat, step_lat;
    int   dec_tab [0:3];

    // Monitor / model state (written by the negedge process only)
    int   cyc, n_start, n_int, n_cv;
    int   start_viol, lat_viol, data_viol, idx_viol;
    int   min_gap, last_start, first_start, first_err;
    int   cls_log [0:3];
    int   adc_cnt, step_cnt, step_hold, rdy_cnt, rdy_hold, nsteps, nframes;
    logic rdy_prev;
    logic [DATA_SIZE-1:0] adc_next, last_adc;

    int n_cmp = 0;
    int n_bad = 0;

    assign net_step = (cls_auto != 0) ? step_m : man_step;

    adc_frame_seq #(
        .NUM_IN    (NUM_IN),
        .ADDR_SIZE (ADDR_SIZE),
        .DATA_SIZE (DATA_SIZE),
        .PERIOD_W  (PERIOD_W),
        .TIMEOUT   (TIMEOUT),
        .FRAME_W   (FRAME_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .period      (period),
        .adc_start   (adc_start),
        .adc_done    (adc_done),
        .adc_data    (adc_data),
        .net_int     (net_int),
        .net_data    (net_data),
        .net_step    (net_step),
        .net_ready   (net_ready),
        .net_out     (net_out),
        .class_valid (class_valid),
        .class_out   (class_out),
        .frame_cnt   (frame_cnt),
        .sample_idx  (sample_idx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun     (overrun)
    );

    initial forever #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs_vec();
        return 32'({adc_start, net_int, net_data, class_valid, class_out,
                    frame_cnt, sample_idx, busy, timeout_err, overrun});
    endfunction

    // Bounded wait: 0 class_valid count, 1 net_int count, 2 sample_idx value, 3 timeout_err.
    task automatic wait_evt(input string tag, input int sel, input int val, input int budget);
        int k;
        bit hit;
        k   = 0;
        hit = 1'b0;
        while (!hit && k < budget) begin
            @(negedge clk); #1;
            k++;
            case (sel)
                0:       hit = (n_cv >= val);
                1:       hit = (n_int >= val);
                2:       hit = (int'(sample_idx) == val);
                default: hit = (timeout_err == 1'b1);
            endcase
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk); #1;
        reset    = 1'b0;
        enable   = 1'b0;
        man_step = 1'b0;
        cls_auto = 1;
        adc_resp = 1;
        adc_lat  = 3;
        step_lat = 4;
        period   = 16'd4;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
    endtask

    // Monitor first, then the ADC and classifier models, all on the falling edge.
    always @(negedge clk) begin
        if (!reset) begin
            cyc = 0; n_start = 0; n_int = 0; n_cv = 0;
            start_viol = 0; lat_viol = 0; data_viol = 0; idx_viol = 0;
            min_gap = 1000; last_start = -1; first_start = -1; first_err = -1;
            for (int i = 0; i < 4; i++) cls_log[i] = -1;
            adc_cnt = 0; step_cnt = 0; step_hold = 0; rdy_cnt = 0; rdy_hold = 0;
            nsteps = 0; nframes = 0; rdy_prev = 1'b0;
            adc_next = 8'h5A; last_adc = 8'h00;
            adc_done = 1'b0; adc_data = 8'h00;
            step_m = 1'b0; net_ready = 1'b0; net_out = 1'b0;
        end else begin
            cyc++;
            if (adc_start) begin
                n_start++;
                if (adc_cnt > 0) start_viol++;
                if (last_start >= 0 && (cyc - last_start) < min_gap) min_gap = cyc - last_start;
                if (first_start < 0) first_start = cyc;
                last_start = cyc;
            end
            if (adc_done && !net_int) lat_viol++;
            if (net_int) begin
                n_int++;
                if (net_data !== last_adc) data_viol++;
            end
            if (net_ready && !rdy_prev && !class_valid) lat_viol++;
            if (class_valid) begin
                if (n_cv < 4) cls_log[n_cv] = int'(class_out);
                n_cv++;
                if (sample_idx != '0) idx_viol++;
            end
            if (timeout_err && first_err < 0) first_err = cyc;

            adc_done = 1'b0;
            if (adc_cnt > 0) begin
                adc_cnt--;
                if (adc_cnt == 0) begin
                    adc_done = 1'b1;
                    adc_data = adc_next;
                    last_adc = adc_next;
                    adc_next = adc_next + 8'h13;
                end
            end
            if (adc_start && adc_resp != 0) adc_cnt = adc_lat;

            rdy_prev = net_ready;
            if (step_hold > 0) begin
                step_hold--;
                if (step_hold == 0) step_m = 1'b0;
            end
            if (step_cnt > 0) begin
                step_cnt--;
                if (step_cnt == 0) begin
                    step_m    = 1'b1;
                    step_hold = 2;
                    nsteps++;
                    if (nsteps % NUM_IN == 0) rdy_cnt = 3;
                end
            end
            if (net_int && cls_auto != 0) step_cnt = step_lat;
            if (rdy_hold > 0) begin
                rdy_hold--;
                if (rdy_hold == 0) net_ready = 1'b0;
            end
            if (rdy_cnt > 0) begin
                rdy_cnt--;
                if (rdy_cnt == 0) begin
                    net_ready = 1'b1;
                    net_out   = (dec_tab[nframes % 4] != 0);
                    rdy_hold  = 2;
                    nframes++;
                end
            end
        end
    end

    initial begin
        reset = 1'b0; enable = 1'b0; period = 16'd4; man_step = 1'b0;
        cls_auto = 1; adc_resp = 1; adc_lat = 3; step_lat = 4;
        for (int i = 0; i < 4; i++) dec_tab[i] = 0;

        // Reset state
        @(negedge clk); #1;
        check_eq("rst_outputs", outs_vec(), 32'd0);
        check_eq("rst_state", 32'(dut.r_state), 32'(ST_IDLE));

        // Single frame, decision 1
        do_reset();
        dec_tab[0] = 1;
        enable = 1'b1;
        wait_evt("f1_wait_cv", 0, 1, 1500);
        enable = 1'b0;
        repeat (3) @(negedge clk); #1;
        check_eq("f1_n_int", 32'(n_int), 32'd16);
        check_eq("f1_n_start", 32'(n_start), 32'd16);
        check_eq("f1_n_cv", 32'(n_cv), 32'd1);
        check_eq("f1_class_out", 32'(class_out), 32'd1);
        check_eq("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check_eq("f1_idx_zero", 32'(sample_idx), 32'd0);
        check_eq("f1_start_gap_ge4", 32'(min_gap >= 4), 32'd1);
        check_eq("f1_latency_viol", 32'(lat_viol), 32'd0);
        check_eq("f1_data_viol", 32'(data_viol), 32'd0);
        check_eq("f1_timeout_err", 32'(timeout_err), 32'd0);

        // Two frames back to back, decisions 0 then 1
        do_reset();
        dec_tab[0] = 0;
        dec_tab[1] = 1;
        enable = 1'b1;
        wait_evt("f2_wait_cv", 0, 2, 3000);
        enable = 1'b0;
        repeat (2) @(negedge clk); #1;
        check_eq("f2_class_seq0", 32'(cls_log[0]), 32'd0);
        check_eq("f2_class_seq1", 32'(cls_log[1]), 32'd1);
        check_eq("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        check_eq("f2_n_int", 32'(n_int), 32'd32);
        check_eq("f2_idx_at_valid", 32'(idx_viol), 32'd0);
        check_eq("f2_class_out_kept", 32'(class_out), 32'd1);
        check_eq("f2_busy_idle", 32'(busy), 32'd0);

        // Restart and assert reset asynchronously mid-frame
        enable = 1'b1;
        wait_evt("mid_wait_idx7", 2, 7, 1500);
        #1 reset = 1'b0;
        #1;
        check_eq("async_rst_outputs", outs_vec(), 32'd0);

        // net_step already high when the sample is issued
        do_reset();
        cls_auto = 0;
        man_step = 1'b1;
        enable   = 1'b1;
        wait_evt("stp_wait_int", 1, 1, 200);
        repeat (6) @(negedge clk); #1;
        check_eq("stp_high_no_adv", 32'(sample_idx), 32'd0);
        check_eq("stp_net_data_held", 32'(net_data), 32'h5A);
        check_eq("stp_one_start", 32'(n_start), 32'd1);
        man_step = 1'b0;
        repeat (2) @(negedge clk); #1;
        check_eq("stp_fall_no_adv", 32'(sample_idx), 32'd0);
        man_step = 1'b1;
        repeat (2) @(negedge clk); #1;
        check_eq("stp_rise_adv", 32'(sample_idx), 32'd1);

        // ADC never answers
        do_reset();
        adc_resp = 0;
        enable   = 1'b1;
        wait_evt("to_wait_err", 3, 1, 600);
        check_eq("to_wait_cycles", 32'(first_err - first_start), 32'd255);
        check_eq("to_state_err", 32'(dut.r_state), 32'(ST_ERR));
        check_eq("to_busy", 32'(busy), 32'd1);
        check_eq("to_idx_zero", 32'(sample_idx), 32'd0);
        check_eq("to_overrun_set", 32'(overrun), 32'd1);
        enable = 1'b0;
        @(negedge clk); #1;
        check_eq("to_err_cleared", 32'(timeout_err), 32'd0);
        check_eq("to_overrun_cleared", 32'(overrun), 32'd0);
        check_eq("to_state_idle", 32'(dut.r_state), 32'(ST_IDLE));

        // period=1 with a slow ADC
        do_reset();
        period  = 16'd1;
        adc_lat = 6;
        enable  = 1'b1;
        wait_evt("ov_wait_int1", 1, 1, 200);
        check_eq("ov_overrun", 32'(overrun), 32'd1);
        check_eq("ov_one_start", 32'(n_start), 32'd1);
        wait_evt("ov_wait_int3", 1, 3, 300);
        check_eq("ov_start_in_conv", 32'(start_viol), 32'd0);
        check_eq("ov_starts_eq_ints", 32'(n_start), 32'd3);
        check_eq("ov_latency_viol", 32'(lat_viol), 32'd0);
        enable = 1'b0;
        @(negedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
